// File: rtl/mem_port_arbiter_pkg.sv
// mem_arb_pkg: shared state/grant encodings and default RAM geometry for the memory port arbiter
package mem_arb_pkg;
  localparam int DEPTH_DEF = 1024;
  localparam int IDX_W_DEF = 10;
  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;
  typedef enum logic [1:0] {GNT_NONE, GNT_IF, GNT_MEM} gnt_t;
endpackage

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: requester handshakes and RAM port bundled for the arbiter
interface mem_port_arbiter_if #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 64,
  parameter int IDX_W  = 10
);
  logic              if_req, if_ready, if_err;
  logic [ADDR_W-1:0] if_addr, mem_addr;
  logic [DATA_W-1:0] if_rdata, mem_rdata, mem_wdata, dm_wdata, dm_rdata;
  logic              mem_rd, mem_wr, mem_ready, mem_err;
  logic              dm_en, dm_we, busy;
  logic [IDX_W-1:0]  dm_index;
  modport slave (
    input  if_req, if_addr, mem_rd, mem_wr, mem_addr, mem_wdata, dm_rdata,
    output if_ready, if_rdata, if_err, mem_ready, mem_rdata, mem_err,
           dm_en, dm_we, dm_index, dm_wdata, busy
  );
  modport master (
    output if_req, if_addr, mem_rd, mem_wr, mem_addr, mem_wdata, dm_rdata,
    input  if_ready, if_rdata, if_err, mem_ready, mem_rdata, mem_err,
           dm_en, dm_we, dm_index, dm_wdata, busy
  );
endinterface

// File: rtl/mem_port_arbiter_addr_check.sv
// mem_addr_check: flags out-of-range doubleword index, misaligned address or conflicting rd/wr
module mem_addr_check #(
  parameter int ADDR_W = 64,
  parameter int DEPTH  = 1024
) (
  input  logic [ADDR_W-1:0] addr,
  input  logic              rd,
  input  logic              wr,
  output logic              illegal
);
  logic [ADDR_W-1:0] idx;
  assign idx     = addr >> 3;
  assign illegal = idx > ADDR_W'(DEPTH - 1) || addr[1:0] != 2'b00 || (rd && wr);
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one fixed-latency RAM port between IF and MEM requesters, MEM first with bounded bursts
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int DATA_W        = 64,
  parameter int ADDR_W        = 64,
  parameter int DEPTH         = DEPTH_DEF,
  parameter int IDX_W         = IDX_W_DEF,
  parameter int LAT           = 1,
  parameter int MAX_MEM_BURST = 4
) (
  input logic clk,
  input logic rst_n,
  mem_port_arbiter_if.slave bus
);
  localparam int BW = $clog2(MAX_MEM_BURST + 1);
  localparam int CW = LAT > 1 ? $clog2(LAT) : 1;
  state_t            state_q;
  gnt_t              gnt_q, gnt_d;
  logic [BW-1:0]     burst_q;
  logic [CW-1:0]     wcnt_q;
  logic              wr_q, busy_q, dm_en_q, dm_we_q;
  logic              if_ready_q, if_err_q, mem_ready_q, mem_err_q;
  logic [DATA_W-1:0] if_rdata_q, mem_rdata_q, dm_wdata_q;
  logic [IDX_W-1:0]  dm_index_q;
  logic              mem_pend, sel_rd, sel_wr, illegal;
  logic [ADDR_W-1:0] sel_addr;
  always_comb begin
    mem_pend = bus.mem_rd | bus.mem_wr;
    gnt_d    = (mem_pend && !(bus.if_req && burst_q == BW'(MAX_MEM_BURST))) ? GNT_MEM :
               bus.if_req ? GNT_IF : GNT_NONE;
    sel_addr = gnt_d == GNT_IF ? bus.if_addr : bus.mem_addr;
    sel_rd   = gnt_d == GNT_IF || bus.mem_rd;
    sel_wr   = gnt_d == GNT_MEM && bus.mem_wr;
  end
  mem_addr_check #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_chk (
    .addr(sel_addr), .rd(sel_rd), .wr(sel_wr), .illegal(illegal)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      gnt_q       <= GNT_NONE;
      burst_q     <= '0;
      wcnt_q      <= '0;
      wr_q        <= 1'b0;
      busy_q      <= 1'b0;
      dm_en_q     <= 1'b0;
      dm_we_q     <= 1'b0;
      dm_index_q  <= '0;
      dm_wdata_q  <= '0;
      if_ready_q  <= 1'b0;
      if_err_q    <= 1'b0;
      if_rdata_q  <= '0;
      mem_ready_q <= 1'b0;
      mem_err_q   <= 1'b0;
      mem_rdata_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          burst_q <= (gnt_d == GNT_IF || !bus.if_req) ? '0 :
                     gnt_d == GNT_MEM ? burst_q + BW'(1) : burst_q;
          gnt_q   <= gnt_d;
          wr_q    <= sel_wr;
          if (gnt_d != GNT_NONE) begin
            busy_q <= 1'b1;
            if (illegal) begin
              state_q     <= RESP;
              if_ready_q  <= gnt_d == GNT_IF;
              if_err_q    <= gnt_d == GNT_IF;
              mem_ready_q <= gnt_d == GNT_MEM;
              mem_err_q   <= gnt_d == GNT_MEM;
            end else begin
              state_q    <= ACCESS;
              dm_en_q    <= 1'b1;
              dm_we_q    <= sel_wr;
              dm_index_q <= sel_addr[IDX_W+2:3];
              dm_wdata_q <= sel_wr ? bus.mem_wdata : '0;
            end
          end
        end
        ACCESS: begin
          state_q <= WAIT;
          dm_en_q <= 1'b0;
          dm_we_q <= 1'b0;
          wcnt_q  <= CW'(LAT - 1);
        end
        WAIT: begin
          if (wcnt_q == '0) begin
            state_q     <= RESP;
            if_ready_q  <= gnt_q == GNT_IF;
            mem_ready_q <= gnt_q == GNT_MEM;
            if_rdata_q  <= gnt_q == GNT_IF ? bus.dm_rdata : '0;
            mem_rdata_q <= (gnt_q == GNT_MEM && !wr_q) ? bus.dm_rdata : '0;
          end else begin
            wcnt_q <= wcnt_q - CW'(1);
          end
        end
        RESP: begin
          state_q     <= IDLE;
          busy_q      <= 1'b0;
          if_ready_q  <= 1'b0;
          if_err_q    <= 1'b0;
          if_rdata_q  <= '0;
          mem_ready_q <= 1'b0;
          mem_err_q   <= 1'b0;
          mem_rdata_q <= '0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign bus.if_ready  = if_ready_q;
  assign bus.if_err    = if_err_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.mem_ready = mem_ready_q;
  assign bus.mem_err   = mem_err_q;
  assign bus.mem_rdata = mem_rdata_q;
  assign bus.dm_en     = dm_en_q;
  assign bus.dm_we     = dm_we_q;
  assign bus.dm_index  = dm_index_q;
  assign bus.dm_wdata  = dm_wdata_q;
  assign bus.busy      = busy_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed checks on a LAT=1 and a LAT=3 arbiter sharing the same requester stimulus
module tb_mem_port_arbiter;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        if_req = 1'b0, mem_rd = 1'b0, mem_wr = 1'b0;
  logic [63:0] if_addr = '0, mem_addr = '0, mem_wdata = '0;
  logic [63:0] ram_a [1024];
  logic [63:0] ram_b [1024];
  logic [63:0] ra, rb1, rb2, rb3;
  int n_chk = 0, n_fail = 0, en_cnt = 0, we_cnt = 0, rdy_cnt = 0;
  int e0, w0, r0, got;
  mem_port_arbiter_if ba ();
  mem_port_arbiter_if bb ();
  assign ba.if_req    = if_req;
  assign ba.if_addr   = if_addr;
  assign ba.mem_rd    = mem_rd;
  assign ba.mem_wr    = mem_wr;
  assign ba.mem_addr  = mem_addr;
  assign ba.mem_wdata = mem_wdata;
  assign ba.dm_rdata  = ra;
  assign bb.if_req    = if_req;
  assign bb.if_addr   = if_addr;
  assign bb.mem_rd    = mem_rd;
  assign bb.mem_wr    = mem_wr;
  assign bb.mem_addr  = mem_addr;
  assign bb.mem_wdata = mem_wdata;
  assign bb.dm_rdata  = rb3;
  mem_port_arbiter #(.LAT(1)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ba));
  mem_port_arbiter #(.LAT(3)) dut_b (.clk(clk), .rst_n(rst_n), .bus(bb));
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (!rst_n) begin
      ram_a[2] <= 64'hDEADBEEF;
      ram_b[2] <= 64'hDEADBEEF;
      ram_a[4] <= 64'h1234;
      ram_b[4] <= 64'h1234;
    end
    if (ba.dm_en && ba.dm_we) ram_a[ba.dm_index] <= ba.dm_wdata;
    if (bb.dm_en && bb.dm_we) ram_b[bb.dm_index] <= bb.dm_wdata;
    ra  <= ram_a[ba.dm_index];
    rb1 <= ram_b[bb.dm_index];
    rb2 <= rb1;
    rb3 <= rb2;
    if (ba.dm_en) en_cnt <= en_cnt + 1;
    if (ba.dm_we) we_cnt <= we_cnt + 1;
    if (ba.if_ready || ba.mem_ready) rdy_cnt <= rdy_cnt + 1;
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask
  initial begin
    repeat (3) tick();
    check("rst_busy", ba.busy, 0);
    check("rst_dm_en", ba.dm_en, 0);
    check("rst_ready", {ba.if_ready, ba.mem_ready, ba.if_err, ba.mem_err}, 0);
    check("rst_index", ba.dm_index, 0);
    rst_n = 1'b1;
    tick();
    // 1: legal load, LAT=1
    mem_rd = 1'b1; mem_addr = 64'h10;
    tick();
    check("t1_dm_en", ba.dm_en, 1);
    check("t1_index", ba.dm_index, 2);
    check("t1_we", ba.dm_we, 0);
    check("t1_busy", ba.busy, 1);
    tick();
    check("t1_c2_ready", ba.mem_ready, 0);
    check("t1_c2_dm_en", ba.dm_en, 0);
    tick();
    check("t1_ready", ba.mem_ready, 1);
    check("t1_rdata", ba.mem_rdata, 64'hDEADBEEF);
    check("t1_err", ba.mem_err, 0);
    check("t1_if_ready", ba.if_ready, 0);
    mem_rd = 1'b0;
    repeat (8) tick();
    // 2: misaligned IF fetch
    e0 = en_cnt;
    if_req = 1'b1; if_addr = 64'h2002;
    tick();
    check("t2_if_ready", ba.if_ready, 1);
    check("t2_if_err", ba.if_err, 1);
    check("t2_if_rdata", ba.if_rdata, 0);
    check("t2_mem_ready", ba.mem_ready, 0);
    if_req = 1'b0;
    repeat (4) tick();
    check("t2_no_dm_en", en_cnt, e0);
    // 3: out-of-range store, then rd+wr conflict
    w0 = we_cnt;
    mem_wr = 1'b1; mem_addr = 64'h2000; mem_wdata = 64'h77;
    tick();
    check("t3a_ready", ba.mem_ready, 1);
    check("t3a_err", ba.mem_err, 1);
    mem_wr = 1'b0;
    tick();
    mem_rd = 1'b1; mem_wr = 1'b1; mem_addr = 64'h8;
    tick();
    check("t3b_ready", ba.mem_ready, 1);
    check("t3b_err", ba.mem_err, 1);
    mem_rd = 1'b0; mem_wr = 1'b0;
    repeat (4) tick();
    check("t3_no_we", we_cnt, w0);
    check("t3_no_en", en_cnt, e0);
    // 4: burst limit with both requesters held
    mem_rd = 1'b1; mem_addr = 64'h10; if_req = 1'b1; if_addr = 64'h20;
    got = 0;
    for (int c = 0; c < 200 && got < 10; c++) begin
      tick();
      if (ba.mem_ready || ba.if_ready) begin
        check("t4_grant", {ba.if_ready, ba.mem_ready}, (got % 5 == 4) ? 2'b10 : 2'b01);
        if (ba.if_ready) check("t4_if_rdata", ba.if_rdata, 64'h1234);
        got++;
      end
    end
    check("t4_grant_count", got, 10);
    mem_rd = 1'b0; if_req = 1'b0;
    repeat (12) tick();
    // 5: store on the LAT=3 instance
    mem_wr = 1'b1; mem_addr = 64'h18; mem_wdata = 64'h55;
    tick();
    check("t5_dm_en", bb.dm_en, 1);
    check("t5_dm_we", bb.dm_we, 1);
    check("t5_index", bb.dm_index, 3);
    check("t5_wdata", bb.dm_wdata, 64'h55);
    check("t5_busy1", bb.busy, 1);
    for (int c = 2; c <= 4; c++) begin
      tick();
      check("t5_busy_mid", bb.busy, 1);
      check("t5_no_ready", bb.mem_ready, 0);
    end
    tick();
    check("t5_ready", bb.mem_ready, 1);
    check("t5_rdata", bb.mem_rdata, 0);
    check("t5_busy5", bb.busy, 1);
    mem_wr = 1'b0;
    tick();
    check("t5_idle", bb.busy, 0);
    check("t5_ram", ram_b[3], 64'h55);
    repeat (8) tick();
    // 6: asynchronous reset during WAIT
    mem_rd = 1'b1; mem_addr = 64'h10;
    tick();
    tick();
    check("t6_in_wait", {ba.busy, ba.dm_en}, 2'b10);
    #2 rst_n = 1'b0;
    #1;
    check("t6_busy", ba.busy, 0);
    check("t6_outs", {ba.dm_en, ba.dm_we, ba.if_ready, ba.mem_ready, ba.if_err, ba.mem_err}, 0);
    check("t6_rdata", ba.mem_rdata, 0);
    mem_rd = 1'b0;
    e0 = en_cnt; r0 = rdy_cnt;
    tick();
    rst_n = 1'b1;
    repeat (10) tick();
    check("t6_no_ready", rdy_cnt, r0);
    check("t6_no_en", en_cnt, e0);
    check("t6_idle", ba.busy, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares the single-port data memory between the instruction-fetch requester (IF) and the MEM-stage load/store requester. It performs the same address legality check the MEM stage applies: a doubleword index beyond DEPTH-1, or address[1:0] != 0, is illegal. Illegal requests never reach the memory. Legal requests are sequenced through a fixed-latency synchronous RAM with a one-cycle ready pulse per transaction.

Parameters:
DATA_W, 64, data width of the RAM and of both requester data buses.
ADDR_W, 64, byte-address width of requester addresses.
DEPTH, 1024, RAM depth in doublewords.
IDX_W, 10, RAM index width; must equal clog2(DEPTH).
LAT, 1, RAM read latency in cycles after the dm_en cycle; must be >= 1.
MAX_MEM_BURST, 4, maximum consecutive MEM grants while IF is waiting.

Ports:
clk  in  1  clock; all logic on the rising edge.
rst_n  in  1  asynchronous, active-low reset.
if_req  in  1  IF read request; held until if_ready.
if_addr  in  ADDR_W  IF byte address; stable while if_req is high.
if_ready  out  1  one-cycle completion pulse for IF.
if_rdata  out  DATA_W  doubleword read for IF; valid with if_ready.
if_err  out  1  IF address illegal; valid with if_ready.
mem_rd  in  1  MEM load request; held until mem_ready.
mem_wr  in  1  MEM store request; held until mem_ready.
mem_addr  in  ADDR_W  MEM byte address.
mem_wdata  in  DATA_W  store data.
mem_ready  out  1  one-cycle completion pulse for MEM.
mem_rdata  out  DATA_W  load data; valid with mem_ready; 0 for stores.
mem_err  out  1  illegal MEM request; valid with mem_ready.
dm_en  out  1  RAM access strobe.
dm_we  out  1  RAM write enable; only ever high together with dm_en.
dm_index  out  IDX_W  RAM index, taken from address[IDX_W+2:3].
dm_wdata  out  DATA_W  RAM write data.
dm_rdata  in  DATA_W  RAM read data; valid LAT cycles after the dm_en cycle.
busy  out  1  high in every state except IDLE.

Behaviour:
- Reset:
  - All outputs are 0; state is IDLE; burst counter is 0.
  - Assertion mid-transaction abandons it: no ready pulse, no further dm_en.
  - A write strobe already issued is not repeated.
- States: IDLE, ACCESS, WAIT, RESP. All outputs are registered.
- IDLE selects a requester (see Arbitration) and samples its request. Exactly one of these happens:
  - Illegal request (index > DEPTH-1, address[1:0] != 0, or mem_rd and mem_wr both high): go to RESP with err=1. No dm_en is issued.
  - Legal request: go to ACCESS.
  - No request: stay in IDLE.
- ACCESS lasts 1 cycle.
  - dm_en=1 and dm_index is driven.
  - For a store, dm_we=1 and dm_wdata is driven.
  - Next state is WAIT.
- WAIT lasts exactly LAT cycles, using a counter loaded with LAT-1.
  - On the last WAIT cycle, dm_rdata is captured for loads.
  - Next state is RESP.
- RESP lasts 1 cycle.
  - The granted requester's ready pulses together with its rdata and err.
  - The other requester's outputs stay 0.
  - Next state is IDLE.
- Latency, counting the IDLE sampling cycle as cycle 0:
  - Legal access: ready in cycle LAT+2.
  - Illegal access: ready in cycle 1.
- Requests are not sampled in ACCESS, WAIT or RESP. A requester changes its request at the edge that ends its RESP cycle, so a back-to-back request is seen in the following IDLE cycle.
- Arbitration, evaluated in IDLE only:
  - MEM has priority over IF.
  - The burst counter increments on each MEM grant made while if_req is high.
  - If the counter equals MAX_MEM_BURST and both requesters are pending, IF is granted.
  - The counter clears on any IF grant, and in any IDLE cycle with if_req low.
- A store reports mem_rdata=0. An illegal store never asserts dm_we.

Decomposition:
- Package mem_arb_pkg holds:
  - the state enum (IDLE, ACCESS, WAIT, RESP);
  - the grant enum (GNT_NONE, GNT_IF, GNT_MEM);
  - the DEPTH and IDX_W defaults.
- One sub-module, mem_addr_check: combinational legality check with inputs addr, rd, wr and output illegal. It is instantiated once, on the muxed address of the selected requester.

Test Plan:
1. LAT=1; RAM index 2 preloaded with 0xDEADBEEF; mem_rd=1, mem_addr=0x10 in cycle 0 -> dm_en=1 with dm_index=2 in cycle 1; mem_ready=1 with mem_rdata=0xDEADBEEF and mem_err=0 in cycle 3; if_ready stays 0.
2. if_req=1 with if_addr=0x2002 -> if_ready=1 and if_err=1 in cycle 1; dm_en is never 1.
3. mem_wr=1 with mem_addr=0x2000 (index 1024) -> mem_err=1 in cycle 1; dm_we is never 1. Then mem_rd and mem_wr both high at address 0x8 -> mem_err=1 in cycle 1.
4. MAX_MEM_BURST=4; mem_rd and if_req held continuously, each requester re-asserting immediately after its ready -> grant sequence MEM,MEM,MEM,MEM,IF,MEM,MEM,MEM,MEM,IF.
5. LAT=3; mem_wr=1, mem_addr=0x18, mem_wdata=0x55 -> dm_en=1, dm_we=1, dm_index=3, dm_wdata=0x55 in cycle 1; mem_ready=1 with mem_rdata=0 in cycle 5; busy=1 in cycles 1 through 5.
6. rst_n driven low in the middle of a WAIT cycle -> all outputs 0 immediately; after release, state is IDLE and no ready pulse is ever produced for the abandoned request.
